// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner -- per-channel sync, debounce, edge detect, auto-repeat
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW      = $clog2(MAX_RPT);
  localparam int CW      = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  // Synchroniser reset value is the pin level of a released button.
  localparam logic          RAW_IDLE    = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_ch
      logic          sync1, sync2;
      logic          pressed, differ, accept, rise, fall;
      logic [CW-1:0] db_cnt;
      logic          level;
      logic          pulse, pulse_next;
      state_t        state, state_next;
      logic [TW-1:0] timer, timer_next;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1 <= RAW_IDLE;
          sync2 <= RAW_IDLE;
        end else begin
          sync1 <= btn_raw[i];
          sync2 <= sync1;
        end
      end

      assign pressed = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
      assign differ  = (pressed != level);
      assign accept  = differ && (db_cnt == DB_LAST);
      assign rise    = accept && !level;
      assign fall    = accept && level;

      // Any agreement with the current level discards accumulated credit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          db_cnt <= '0;
          level  <= 1'b0;
        end else begin
          if (!differ || accept)
            db_cnt <= '0;
          else
            db_cnt <= db_cnt + 1'b1;
          if (accept)
            level <= ~level;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= IDLE;
          timer <= '0;
          pulse <= 1'b0;
        end else begin
          state <= state_next;
          timer <= timer_next;
          pulse <= pulse_next;
        end
      end

      // Release is checked first so a pulse due on the falling edge is dropped.
      always_comb begin
        state_next = state;
        timer_next = timer;
        pulse_next = 1'b0;
        case (state)
          IDLE: begin
            timer_next = '0;
            if (rise) begin
              pulse_next = 1'b1;
              state_next = HOLD;
            end
          end
          HOLD: begin
            if (fall) begin
              state_next = IDLE;
              timer_next = '0;
            end else if (!repeat_en) begin
              timer_next = '0;
            end else if (timer == DELAY_LAST) begin
              pulse_next = 1'b1;
              timer_next = '0;
              state_next = REPEAT;
            end else begin
              timer_next = timer + 1'b1;
            end
          end
          REPEAT: begin
            if (fall) begin
              state_next = IDLE;
              timer_next = '0;
            end else if (!repeat_en) begin
              state_next = HOLD;
              timer_next = '0;
            end else if (timer == PERIOD_LAST) begin
              pulse_next = 1'b1;
              timer_next = '0;
            end else begin
              timer_next = timer + 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
            timer_next = '0;
          end
        endcase
      end

      assign btn_level[i] = level;
      assign btn_pulse[i] = pulse;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
`default_nettype none

module tb_button_conditioner;

  localparam int NUM_BTN = 2;

  logic               clk;
  logic               reset;
  logic [NUM_BTN-1:0] btn_raw;
  logic               repeat_en;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;

  int passed = 0;
  int total  = 0;

  button_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after an edge; inputs set next are sampled at E0.
  task automatic apply_reset();
    reset     = 1'b1;
    btn_raw   = '1;
    repeat_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    btn_raw   = '1;
    repeat_en = 1'b0;
    #1;
    total++;
    if (btn_level !== 2'b00 || btn_pulse !== 2'b00)
      $display("FAIL reset_async: level=%b pulse=%b expected 00/00", btn_level, btn_pulse);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (btn_level !== 2'b00 || btn_pulse !== 2'b00)
      $display("FAIL reset_clocked: level=%b pulse=%b expected 00/00", btn_level, btn_pulse);
    else passed++;
  endtask

  task automatic test_clean_press();
    logic [1:0] el, ep;
    apply_reset();
    btn_raw = 2'b10;
    for (int k = 0; k <= 28; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 5 && k < 25)};
      ep = {1'b0, (k == 5)};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL clean_press E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
      btn_raw = (k + 1 < 20) ? 2'b10 : 2'b11;
    end
  endtask

  task automatic test_bounce();
    logic [1:0] el, ep;
    int j;
    apply_reset();
    btn_raw = 2'b10;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 8)};
      ep = {1'b0, (k == 8)};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL bounce E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
      j = k + 1;
      btn_raw = (j == 2) ? 2'b11 : 2'b10;
    end
  endtask

  task automatic test_auto_repeat();
    logic [1:0] el, ep;
    apply_reset();
    repeat_en = 1'b1;
    btn_raw   = 2'b10;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 5 && k < 34)};
      ep = {1'b0, (k inside {5, 15, 18, 21, 24, 27, 30, 33})};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL auto_repeat E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
      btn_raw = (k + 1 <= 28) ? 2'b10 : 2'b11;
    end
  endtask

  task automatic test_repeat_gating();
    logic [1:0] el, ep;
    int j;
    apply_reset();
    repeat_en = 1'b1;
    btn_raw   = 2'b10;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 5 && k < 34)};
      ep = {1'b0, (k inside {5, 15, 30, 33})};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL repeat_gating E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
      j = k + 1;
      btn_raw   = (j <= 28) ? 2'b10 : 2'b11;
      repeat_en = !(j >= 18 && j <= 20);
    end
  endtask

  task automatic test_multi_channel();
    logic [1:0] el, ep;
    apply_reset();
    btn_raw = 2'b00;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 5) ? 2'b11 : 2'b00;
      ep = (k == 5) ? 2'b11 : 2'b00;
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL multi_channel E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [1:0] el, ep;
    apply_reset();
    repeat_en = 1'b1;
    btn_raw   = 2'b10;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 5)};
      ep = {1'b0, (k inside {5, 15})};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL pre_reset E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
    end
    reset = 1'b1;
    #1;
    total++;
    if (btn_level !== 2'b00 || btn_pulse !== 2'b00)
      $display("FAIL reset_immediate: level=%b pulse=%b expected 00/00", btn_level, btn_pulse);
    else passed++;
    for (int k = 17; k <= 19; k++) begin
      @(posedge clk); #1;
      total++;
      if (btn_level !== 2'b00 || btn_pulse !== 2'b00)
        $display("FAIL in_reset E%0d: level=%b pulse=%b expected 00/00", k, btn_level, btn_pulse);
      else passed++;
    end
    reset = 1'b0;
    for (int k = 20; k <= 30; k++) begin
      @(posedge clk); #1;
      el = {1'b0, (k >= 25)};
      ep = {1'b0, (k == 25)};
      total++;
      if (btn_level !== el || btn_pulse !== ep)
        $display("FAIL post_reset E%0d: level=%b pulse=%b expected %b/%b", k, btn_level, btn_pulse, el, ep);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_gating();
    test_multi_channel();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw DE10-Lite push-button inputs into clean single-cycle increment pulses for the clock core's hour/minute set inputs. It sits directly upstream of the clock's time-setting logic, which advances once per clock cycle while its button input is high. Each channel is synchronised, debounced and edge-detected, with optional hold-to-auto-repeat. Without this block a single press would advance the time thousands of times.

## Interface
- NUM_BTN, 2, number of independent button channels (1..8)
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (20 ms at 50 MHz); ≥2
- REPEAT_DELAY, 25000000, cycles from first pulse to first auto-repeat pulse (500 ms); ≥2
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (200 ms); ≥2
- ACTIVE_LOW, 1, 1 = btn_raw low means pressed (DE10-Lite KEYs); 0 = high means pressed
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-high
- btn_raw  input  NUM_BTN  raw asynchronous button pins
- repeat_en  input  1  enables auto-repeat on all channels (driven by the set-mode switch)
- btn_level  output  NUM_BTN  debounced pressed level, active-high
- btn_pulse  output  NUM_BTN  one-cycle increment pulse per accepted press/repeat; connects to the clock's hour/minute set inputs

## Operation
- Per channel, fully independent; all state registered, outputs driven from flops only.
- Sync: 2-flop synchroniser, then polarity normalised to pressed=1.
- Debounce: counter clears whenever the synced value equals btn_level. It increments while they differ. When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles and the counter clears. Any return to the old level before then clears the counter; there is no partial credit.
- FSM states IDLE, HOLD, REPEAT, with timer width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
  - IDLE: a rising btn_level makes btn_pulse=1 on that same edge, clears the timer, and moves to HOLD.
  - HOLD, repeat_en=1: the timer counts. At REPEAT_DELAY-1 → pulse, clear timer, move to REPEAT.
  - HOLD, repeat_en=0: the timer holds at 0 and no pulses are issued.
  - REPEAT, repeat_en=1: at timer REPEAT_PERIOD-1 → pulse, clear timer.
  - REPEAT, repeat_en=0: move to HOLD, clear timer. Re-enabling requires the full REPEAT_DELAY again.
  - HOLD/REPEAT, falling btn_level: move to IDLE, clear timer. Release never generates a pulse.
- btn_pulse is never high for two consecutive cycles (REPEAT_PERIOD ≥2).
- Simultaneous presses on several channels give simultaneous pulses, with no arbitration.

## Timing
- Reset (async assert, sync-safe release): synchroniser flops hold the released value. Counters, timers, btn_level and btn_pulse are all 0, and every FSM is in IDLE. Outputs go to 0 immediately on assertion.
- E0 is the first clk edge sampling a steady press. btn_level rises and the first btn_pulse is high on edge E0+DEBOUNCE_CYCLES+1, i.e. latency DEBOUNCE_CYCLES+2 cycles inclusive.
- Release: btn_level falls with the same latency; btn_pulse stays 0.
- Auto-repeat: the second pulse comes exactly REPEAT_DELAY cycles after the first, and later pulses every REPEAT_PERIOD cycles. The last possible pulse is the one whose edge precedes the btn_level fall.
- A button held through reset release counts as a new press. It produces a pulse DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
- A pulse scheduled on the same edge that btn_level falls is suppressed, because release wins.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=1. "E" means cycle index.
- Clean press: btn_raw[0]=0 from E0 for 20 cycles, repeat_en=0 → btn_level[0] and btn_pulse[0] both rise at E5, pulse is 1 cycle only. Release at E20 → btn_level[0]=0 at E25, no pulse.
- Bounce: btn_raw[0] low E0–E1, high E2, low from E3 held → exactly one pulse, at E8. btn_level stays 0 before E8.
- Auto-repeat: repeat_en=1, press at E0 held to E29 → pulses at E5, E15, E18, E21, E24, E27, E30, E33. btn_level falls at E34 with no pulse.
- Repeat gating: as in the auto-repeat case, but drop repeat_en at E17 and restore at E20 → pulses at E5, E15, E30, E33…
- Multi-channel: btn_raw=2'b00 at E0 → btn_pulse=2'b11 at E5, with no cross-channel interference.
- Reset mid-repeat: assert reset at E17 with the button held → outputs 0 immediately. Deassert before E20, with E20 the first post-reset edge → single new pulse at E25.
